ysyx_23060201_mem_arb: RTL

YSYX_23060201_MEM_ARB -- requirements
Module: ysyx_23060201_mem_arb

---
 rtl/ysyx_23060201_mem_arb_pkg.sv | 15 +
 rtl/ysyx_23060201_mem_arb_tmr.sv | 31 +++
 rtl/ysyx_23060201_mem_arb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060201_mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, requester
// identities and the default lowest legal memory address.
package ysyx_23060201_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [31:0] ARB_MBASE = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060201_mem_arb_tmr.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches LIMIT.
module ysyx_23060201_mem_arb_tmr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Fires while the count steps from LIMIT-1 to LIMIT, so the FSM leaves
  // after exactly LIMIT enabled cycles.
  assign hit_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/ysyx_23060201_mem_arb.sv
// Two-requester (IFU fetch, LSU load/store) arbiter onto a single memory port
// with one transaction in flight, address range check and response timeout.
module ysyx_23060201_mem_arb
  import ysyx_23060201_mem_arb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           TIMEOUT    = 255,
  parameter logic [ADDR_WIDTH-1:0] MBASE      = ADDR_WIDTH'(ARB_MBASE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rsp_data,
  output logic                    ifu_rsp_err,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rsp_rdata,
  output logic                    lsu_rsp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  input  logic                    mem_rsp_err
);

  logic [1:0]              state_q, state_d;
  logic                    owner_q, last_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q, bad_q, err_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
  logic                    grant_ifu, grant_lsu, idle, hs, tmo_hit, resp;

  assign idle      = (state_q == ST_IDLE);
  assign grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_q == OWN_LSU));
  assign grant_lsu = lsu_req_valid && !grant_ifu;
  assign hs        = idle && (grant_ifu || grant_lsu);

  ysyx_23060201_mem_arb_tmr #(
    .LIMIT (TIMEOUT)
  ) u_tmr (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (hs),
    .en_i   ((state_q == ST_REQ) || (state_q == ST_WAIT)),
    .hit_o  (tmo_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_REQ;
      ST_REQ: begin
        if (bad_q || tmo_hit)   state_d = ST_RESP;
        else if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: if (mem_rsp_valid || tmo_hit) state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // rdata/err are cleared at accept so error and timeout exits only need to set err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (hs) begin
          owner_q <= grant_lsu ? OWN_LSU : OWN_IFU;
          last_q  <= grant_lsu ? OWN_LSU : OWN_IFU;
          addr_q  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
          wen_q   <= grant_lsu && lsu_req_wen;
          wdata_q <= grant_lsu ? lsu_req_wdata : '0;
          wmask_q <= grant_lsu ? lsu_req_wmask : '0;
          bad_q   <= (grant_lsu ? lsu_req_addr : ifu_req_addr) < MBASE;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        ST_REQ: if (bad_q || tmo_hit) err_q <= 1'b1;
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q <= wen_q ? '0 : mem_rsp_rdata;
            err_q   <= mem_rsp_err;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ifu_req_ready = idle && grant_ifu;
  assign lsu_req_ready = idle && grant_lsu;

  assign mem_req_valid = (state_q == ST_REQ) && !bad_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  assign resp          = (state_q == ST_RESP);
  assign ifu_rsp_valid = resp && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = resp && (owner_q == OWN_LSU);
  assign ifu_rsp_data  = ifu_rsp_valid ? rdata_q : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && err_q;
  assign lsu_rsp_rdata = lsu_rsp_valid ? rdata_q : '0;
  assign lsu_rsp_err   = lsu_rsp_valid && err_q;

endmodule
